config_chain_loader: RTL and testbench

- Drives the fabric configuration shift chain: prog_out feeds prog_in of the first programmable element, and chain_in returns prog_out of the last element.
- Accepts configuration words over a valid/ready stream and serialises them LSB-first into the chain, pulsing prog_en once per shifted bit.
- Optionally recirculates the chain once and compares popcounts to detect broken or stuck chain links.

---
 rtl/config_chain_loader.sv | 130 +++++++++++++
 tb/tb_config_chain_loader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/config_chain_loader.sv
// Configuration shift-chain loader: serialises a word stream LSB-first into the
// fabric chain, then optionally recirculates it once to compare popcounts.
module config_chain_loader #(
    parameter int CHAIN_LEN = 24,
    parameter int DATA_W    = 8,
    parameter bit VERIFY    = 1'b1
) (
    input  logic              prog_clk,
    input  logic              prog_rst,
    input  logic              start,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              chain_in,
    output logic              prog_out,
    output logic              prog_en,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int PEND_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_VERIFY,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [DATA_W-1:0]  buf_q;
    logic [PEND_W-1:0]  pend_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [CNT_W-1:0]   ver_cnt_q;
    logic [CNT_W-1:0]   ones_load_q;
    logic [CNT_W-1:0]   ones_ver_q;
    logic               busy_q;
    logic               done_q;
    logic               error_q;

    logic [PEND_W-1:0]  take_len;
    logic               load_shift;
    logic               accept;

    // Only the bits that still fit in the chain are ever shifted out of a word.
    always_comb begin
        take_len = PEND_W'(DATA_W);
        if ((CHAIN_LEN - int'(bit_cnt_q)) < DATA_W)
            take_len = PEND_W'(CHAIN_LEN - int'(bit_cnt_q));
    end

    assign load_shift = (state_q == S_LOAD) && (pend_q != '0);
    assign s_ready    = (state_q == S_LOAD) && (pend_q == '0) && (bit_cnt_q < LEN_C);
    assign accept     = s_valid && s_ready;

    assign prog_en  = load_shift || (state_q == S_VERIFY);
    assign prog_out = load_shift ? buf_q[0] :
                      (state_q == S_VERIFY) ? chain_in : 1'b0;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;

    always_ff @(posedge prog_clk) begin
        if (prog_rst) begin
            state_q     <= S_IDLE;
            buf_q       <= '0;
            pend_q      <= '0;
            bit_cnt_q   <= '0;
            ver_cnt_q   <= '0;
            ones_load_q <= '0;
            ones_ver_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q     <= S_LOAD;
                        buf_q       <= '0;
                        pend_q      <= '0;
                        bit_cnt_q   <= '0;
                        ver_cnt_q   <= '0;
                        ones_load_q <= '0;
                        ones_ver_q  <= '0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (load_shift) begin
                        buf_q       <= buf_q >> 1;
                        pend_q      <= pend_q - PEND_W'(1);
                        bit_cnt_q   <= bit_cnt_q + CNT_W'(1);
                        ones_load_q <= ones_load_q + CNT_W'(buf_q[0]);
                        if (bit_cnt_q == LAST_C) begin
                            pend_q <= '0;
                            if (VERIFY) begin
                                state_q <= S_VERIFY;
                            end else begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end else if (accept) begin
                        buf_q  <= s_data;
                        pend_q <= take_len;
                    end
                end
                S_VERIFY: begin
                    // Recirculation: the tail bit re-enters at the head via prog_out.
                    ver_cnt_q  <= ver_cnt_q + CNT_W'(1);
                    ones_ver_q <= ones_ver_q + CNT_W'(chain_in);
                    if (ver_cnt_q == LAST_C) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        error_q <= (ones_ver_q + CNT_W'(chain_in)) != ones_load_q;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: three builds (24/8/verify, 20/8/verify, 24/8/no-verify)
// driving behavioural shift-register chains, checked against a word-image reference.
module tb_config_chain_loader;
    localparam int ND = 3;

    logic          prog_clk = 1'b0;
    logic          prog_rst;
    logic [ND-1:0] start_v, sv, srdy, cin, pout, pen, bsy, dn, er;
    logic [7:0]    sd [ND];

    int nchk = 0;
    int nerr = 0;

    always #5 prog_clk = ~prog_clk;

    config_chain_loader #(.CHAIN_LEN(24), .DATA_W(8), .VERIFY(1'b1)) u_nom (
        .prog_clk(prog_clk), .prog_rst(prog_rst), .start(start_v[0]), .s_data(sd[0]),
        .s_valid(sv[0]), .s_ready(srdy[0]), .chain_in(cin[0]), .prog_out(pout[0]),
        .prog_en(pen[0]), .busy(bsy[0]), .done(dn[0]), .error(er[0]));
    config_chain_loader #(.CHAIN_LEN(20), .DATA_W(8), .VERIFY(1'b1)) u_p20 (
        .prog_clk(prog_clk), .prog_rst(prog_rst), .start(start_v[1]), .s_data(sd[1]),
        .s_valid(sv[1]), .s_ready(srdy[1]), .chain_in(cin[1]), .prog_out(pout[1]),
        .prog_en(pen[1]), .busy(bsy[1]), .done(dn[1]), .error(er[1]));
    config_chain_loader #(.CHAIN_LEN(24), .DATA_W(8), .VERIFY(1'b0)) u_nv (
        .prog_clk(prog_clk), .prog_rst(prog_rst), .start(start_v[2]), .s_data(sd[2]),
        .s_valid(sv[2]), .s_ready(srdy[2]), .chain_in(cin[2]), .prog_out(pout[2]),
        .prog_en(pen[2]), .busy(bsy[2]), .done(dn[2]), .error(er[2]));

    function automatic int len_of(input int d);
        return (d == 1) ? 20 : 24;
    endfunction

    function automatic bit ver_of(input int d);
        return d != 2;
    endfunction

    // Chain model: head at bit len-1, tail at bit 0; optional one-shot loss of bit 10
    // right after the last load shift (a link dropping its stored 1).
    logic [31:0] ch [ND] = '{32'd0, 32'd0, 32'd0};
    int chsh [ND] = '{0, 0, 0};
    int flip_at [ND] = '{-1, -1, -1};

    assign cin[0] = ch[0][0];
    assign cin[1] = ch[1][0];
    assign cin[2] = ch[2][0];

    always @(posedge prog_clk) begin
        logic [31:0] nx;
        for (int d = 0; d < ND; d++) begin
            nx = ch[d];
            if (pen[d]) begin
                nx = (ch[d] >> 1) | ({31'd0, pout[d]} << (len_of(d) - 1));
                if (chsh[d] + 1 == flip_at[d]) nx[10] = 1'b0;
                chsh[d] <= chsh[d] + 1;
            end
            ch[d] <= nx;
        end
    end

    // Monitor, sampled mid-cycle: pulse count, serial stream, transfer count.
    int pcnt [ND] = '{0, 0, 0};
    int xcnt [ND] = '{0, 0, 0};
    bit strm [ND][1024];

    always @(negedge prog_clk) begin
        for (int d = 0; d < ND; d++) begin
            if (pen[d]) begin
                strm[d][pcnt[d] % 1024] <= pout[d];
                pcnt[d] <= pcnt[d] + 1;
            end
            if (sv[d] && srdy[d]) xcnt[d] <= xcnt[d] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offers words[7:0], [15:8], ... on the stream, holding each until taken.
    task automatic run(input int d, input logic [31:0] words, input int gapmax,
                       input bit stuck, input bit mid_start, input bit rst_at10,
                       output int cyc, output bit ok, output int base_p, output int base_x);
        int  wi;
        int  gap;
        bit  xfer;
        base_p = pcnt[d];
        base_x = xcnt[d];
        wi = 0;
        gap = 0;
        cyc = 0;
        ok = 1'b0;
        flip_at[d] = stuck ? chsh[d] + len_of(d) : -1;
        sd[d] = words[7:0];
        sv[d] = 1'b1;
        start_v[d] = 1'b1;
        while (cyc < 600) begin
            xfer = sv[d] && srdy[d];
            @(posedge prog_clk);
            #1;
            start_v[d] = 1'b0;
            cyc++;
            if (xfer) begin
                wi++;
                gap = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
            end
            if (gap > 0) begin
                sv[d] = 1'b0;
                gap--;
            end else begin
                sv[d] = 1'b1;
                sd[d] = words[8*(wi%4) +: 8];
            end
            if (mid_start && cyc == 5) start_v[d] = 1'b1;
            if (rst_at10 && (pcnt[d] - base_p) == 10) begin
                prog_rst = 1'b1;
                @(posedge prog_clk);
                #1;
                prog_rst = 1'b0;
                sv[d] = 1'b0;
                ok = 1'b1;
                return;
            end
            if (dn[d]) begin
                ok = 1'b1;
                break;
            end
        end
        sv[d] = 1'b0;
    endtask

    task automatic do_load(input string tag, input int d, input logic [31:0] words,
                           input int gapmax, input bit stuck, input bit mid_start);
        int          cyc, bp, bx, L, nw, ones_v;
        bit          ok;
        logic [31:0] img, got, exp_ch;
        L = len_of(d);
        nw = (L + 7) / 8;
        img = words & ((32'd1 << L) - 32'd1);
        run(d, words, gapmax, stuck, mid_start, 1'b0, cyc, ok, bp, bx);
        chk({tag, "_reached_done"}, {31'd0, ok}, 32'd1);
        if (gapmax == 0)
            chk({tag, "_done_cycle"}, cyc, 1 + nw + L + (ver_of(d) ? L : 0));
        chk({tag, "_pulses"}, pcnt[d] - bp, ver_of(d) ? 2 * L : L);
        chk({tag, "_transfers"}, xcnt[d] - bx, nw);
        got = '0;
        for (int i = 0; i < L; i++) got[i] = strm[d][(bp + i) % 1024];
        chk({tag, "_load_stream"}, got, img);
        if (ver_of(d)) begin
            ones_v = 0;
            for (int i = 0; i < L; i++) ones_v += int'(strm[d][(bp + L + i) % 1024]);
            chk({tag, "_verify_ones"}, ones_v, $countones(img) - ((stuck && img[10]) ? 1 : 0));
        end
        exp_ch = (stuck && ver_of(d)) ? (img & ~32'h400) : img;
        chk({tag, "_chain"}, ch[d], exp_ch);
        chk({tag, "_busy_done_err"}, {29'd0, bsy[d], dn[d], er[d]},
            {29'd0, 1'b0, 1'b1, stuck && ver_of(d) && img[10]});
    endtask

    initial begin
        int          cyc, bp, bx;
        bit          ok;
        logic [31:0] w;
        prog_rst = 1'b1;
        start_v = '0;
        sv = '0;
        for (int d = 0; d < ND; d++) sd[d] = 8'h00;
        repeat (3) @(posedge prog_clk);
        #1;
        for (int d = 0; d < ND; d++)
            chk($sformatf("reset_outs_%0d", d), {26'd0, srdy[d], pout[d], pen[d], bsy[d], dn[d], er[d]}, 32'd0);
        prog_rst = 1'b0;
        @(posedge prog_clk);
        #1;

        do_load("nominal", 0, 32'h5A0F3CA5, 0, 1'b0, 1'b0);
        do_load("stuck10", 0, 32'h5A0F3CA5, 0, 1'b1, 1'b0);
        do_load("partial20", 1, 32'hFFFFFFFF, 0, 1'b0, 1'b0);
        do_load("backpressure", 0, 32'h5A0F3CA5, 5, 1'b0, 1'b0);

        run(0, 32'h5A0F3CA5, 0, 1'b0, 1'b0, 1'b1, cyc, ok, bp, bx);
        chk("midrst_hit", {31'd0, ok}, 32'd1);
        for (int d = 0; d < ND; d++)
            chk($sformatf("midrst_outs_%0d", d), {26'd0, srdy[d], pout[d], pen[d], bsy[d], dn[d], er[d]}, 32'd0);
        do_load("reload", 0, 32'h5A0F3CA5, 0, 1'b0, 1'b0);

        do_load("noverify_midstart", 2, 32'h5A0F3CA5, 0, 1'b0, 1'b1);

        for (int k = 0; k < 3; k++) begin
            w = $urandom;
            do_load($sformatf("rand_nom_%0d", k), 0, w, int'($urandom_range(3, 0)), 1'b0, 1'b0);
            w = $urandom;
            do_load($sformatf("rand_p20_%0d", k), 1, w, 0, k == 1, 1'b0);
            w = $urandom;
            do_load($sformatf("rand_nv_%0d", k), 2, w, int'($urandom_range(2, 0)), 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
